bcd_convert: RTL and testbench

Sequential binary-to-BCD converter between the pattern-search engine and the seven-segment driver. Accepts the binary match address (`found`) on a start pulse and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. Presents four registered BCD digits (thousands, hundreds, tens, units) to `SS_Driver`. Outputs are held stable between conversions, so the display never sees partially converted digits.

---
 rtl/psa_display_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bcd_convert.sv | 138 +++++++++++++
 tb/tb_bcd_convert.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/psa_display_pkg.sv
// Shared definitions for the pattern-search display path: BCD digit geometry,
// the saturation value and the binary-to-BCD converter state encoding.
package psa_display_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;
  localparam int unsigned BCD_MAX    = 9999;

  // Digit pattern shown when the converted value does not fit in four digits.
  localparam logic [BCD_W-1:0] BCD_SAT_VALUE = {NUM_DIGITS{DIGIT_W'(9)}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added, so the
// following left shift carries into the next decade.
module bcd_digit_adj
  import psa_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_convert.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Digits are registered and only change on the edge that enters DONE, so the
// seven-segment driver never sees a partial result.
// Optional feature: define BCD_SAT_EN to saturate results above 9999 to 9999
// and flag them on ovf; otherwise the digits show the value mod 10000.
module bcd_convert
  import psa_display_pkg::*;
#(
  parameter int unsigned DATA_W = 8  // legal range 4..14
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  bin_in,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] thousands,
  output logic [DIGIT_W-1:0] hundreds,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units,
  output logic               ovf
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  bcd_state_t        state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  digits_q, digits_d;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_shift;

`ifdef BCD_SAT_EN
  logic flag_q, flag_d;
  logic ovf_q, ovf_d;
  logic sat;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .adjusted (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Top bit of the adjusted thousands digit falls off here; that is the mod 10000.
  assign bcd_shift = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};

  // Next-state logic: capture on start, iterate DATA_W times, publish on the last shift.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
`ifdef BCD_SAT_EN
    flag_d   = flag_q;
    ovf_d    = ovf_q;
    sat      = 1'b0;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = CNT_W'(DATA_W);
          state_d = SHIFT;
`ifdef BCD_SAT_EN
          flag_d  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        bcd_d = bcd_shift;
        bin_d = {bin_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
`ifdef BCD_SAT_EN
        flag_d = flag_q | bcd_adj[BCD_W-1];
`endif
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
`ifdef BCD_SAT_EN
          sat      = flag_d | (bcd_shift[BCD_W-1 -: DIGIT_W] > DIGIT_W'(9));
          digits_d = sat ? BCD_SAT_VALUE : bcd_shift;
          ovf_d    = sat;
`else
          digits_d = bcd_shift;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
    end
  end

`ifdef BCD_SAT_EN
  // Overflow tracking: sticky during a conversion, published with the digits.
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign thousands = digits_q[3*DIGIT_W +: DIGIT_W];
  assign hundreds  = digits_q[2*DIGIT_W +: DIGIT_W];
  assign tens      = digits_q[1*DIGIT_W +: DIGIT_W];
  assign units     = digits_q[0 +: DIGIT_W];

endmodule

// File: tb/tb_bcd_convert.sv
// Self-checking bench for bcd_convert: an 8-bit and a 14-bit instance share
// clock and reset. Expected 14-bit results depend on whether BCD_SAT_EN is set.
module tb_bcd_convert;

`ifdef BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start14 = 1'b0;
  logic [7:0] bin8 = '0;
  logic [13:0] bin14 = '0;
  logic       busy8, done8, ovf8, busy14, done14, ovf14;
  logic [3:0] th8, hu8, te8, un8, th14, hu14, te14, un14;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  bcd_convert #(.DATA_W(8)) u_dut8 (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .start     (start8),
    .bin_in    (bin8),
    .busy      (busy8),
    .done      (done8),
    .thousands (th8),
    .hundreds  (hu8),
    .tens      (te8),
    .units     (un8),
    .ovf       (ovf8)
  );

  bcd_convert #(.DATA_W(14)) u_dut14 (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .start     (start14),
    .bin_in    (bin14),
    .busy      (busy14),
    .done      (done14),
    .thousands (th14),
    .hundreds  (hu14),
    .tens      (te14),
    .units     (un14),
    .ovf       (ovf14)
  );

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    if ((busy8 && done8) || (busy14 && done14)) overlap++;
  end

  typedef struct {
    bit          wide;
    logic [13:0] val;
    logic [15:0] exp_dig;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dig8();
    return {th8, hu8, te8, un8};
  endfunction

  function automatic logic [15:0] dig14();
    return {th14, hu14, te14, un14};
  endfunction

  // One-cycle start pulse; measures cycles to done and busy cycles on the way.
  task automatic conv(input bit wide, input logic [13:0] val, output int lat,
                      output int bcnt, output logic [15:0] dig, output logic ov);
    if (wide) begin
      bin14 = val; start14 = 1'b1;
    end else begin
      bin8 = val[7:0]; start8 = 1'b1;
    end
    tick();
    start8 = 1'b0;
    start14 = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!(wide ? done14 : done8) && lat < 40) begin
      if (wide ? busy14 : busy8) bcnt++;
      tick();
      lat++;
    end
    dig = wide ? dig14() : dig8();
    ov  = wide ? ovf14 : ovf8;
    tick();
    chk($sformatf("done_fall_%0d", val), {31'b0, (wide ? done14 : done8)}, 32'd0);
  endtask

  int          lat, bcnt, gap, pulses;
  logic [15:0] dig;
  logic        ov;

  initial begin
    vecs[0]  = '{1'b0, 14'd206,   16'h0206, 1'b0};
    vecs[1]  = '{1'b0, 14'd0,     16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 14'd1,     16'h0001, 1'b0};
    vecs[3]  = '{1'b0, 14'd9,     16'h0009, 1'b0};
    vecs[4]  = '{1'b0, 14'd10,    16'h0010, 1'b0};
    vecs[5]  = '{1'b0, 14'd99,    16'h0099, 1'b0};
    vecs[6]  = '{1'b0, 14'd128,   16'h0128, 1'b0};
    vecs[7]  = '{1'b0, 14'd255,   16'h0255, 1'b0};
    vecs[8]  = '{1'b1, 14'd9999,  16'h9999, 1'b0};
    vecs[9]  = '{1'b1, 14'd8191,  16'h8191, 1'b0};
    vecs[10] = '{1'b1, 14'd12345, SAT ? 16'h9999 : 16'h2345, SAT};
    vecs[11] = '{1'b1, 14'd10000, SAT ? 16'h9999 : 16'h0000, SAT};
    vecs[12] = '{1'b1, 14'd16383, SAT ? 16'h9999 : 16'h6383, SAT};
    vecs[13] = '{1'b1, 14'd100,   16'h0100, 1'b0};

    // Reset state.
    tick();
    chk("rst_dig8", {16'b0, dig8()}, 32'h0);
    chk("rst_dig14", {16'b0, dig14()}, 32'h0);
    chk("rst_flags", {28'b0, busy8, done8, busy14, done14}, 32'h0);
    chk("rst_ovf", {30'b0, ovf8, ovf14}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Table-driven single conversions.
    for (int i = 0; i < 14; i++) begin
      conv(vecs[i].wide, vecs[i].val, lat, bcnt, dig, ov);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].wide ? 14 : 8);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].wide ? 14 : 8);
      chk($sformatf("vec%0d_digits", i), {16'b0, dig}, {16'b0, vecs[i].exp_dig});
      chk($sformatf("vec%0d_ovf", i), {31'b0, ov}, {31'b0, vecs[i].exp_ovf});
    end

    // Back-to-back with start held high: 255 then 0.
    bin8 = 8'd255;
    start8 = 1'b1;
    tick();
    lat = 0;
    while (!done8 && lat < 40) begin tick(); lat++; end
    chk("b2b_first_latency", lat, 8);
    chk("b2b_first_digits", {16'b0, dig8()}, 32'h0255);
    bin8 = 8'd0;  // captured by the start seen in DONE
    tick();
    gap = 0;
    while (!done8 && gap < 40) begin tick(); gap++; end
    start8 = 1'b0;
    // Eight busy cycles separate the two done pulses.
    chk("b2b_gap", gap, 8);
    chk("b2b_second_digits", {16'b0, dig8()}, 32'h0000);
    tick();
    tick();
    chk("b2b_idle", {31'b0, busy8}, 32'd0);

    // start during SHIFT is ignored: 14, then 99 three cycles later.
    bin8 = 8'd14;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    bin8 = 8'd99;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      if (done8) pulses++;
      tick();
    end
    chk("ignore_done_pulses", pulses, 1);
    chk("ignore_digits", {16'b0, dig8()}, 32'h0014);

    // Reset aborts a conversion in flight.
    conv(1'b0, 14'd77, lat, bcnt, dig, ov);
    chk("pre_reset_digits", {16'b0, dig}, 32'h0077);
    bin8 = 8'd150;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_digits", {16'b0, dig8()}, 32'h0000);
    chk("abort_busy", {31'b0, busy8}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (done8) pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done8) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    conv(1'b0, 14'd150, lat, bcnt, dig, ov);
    chk("after_reset_latency", lat, 8);
    chk("after_reset_digits", {16'b0, dig}, 32'h0150);

    chk("busy_done_exclusive", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
